// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types, coin encoding and defaults for the parking kiosk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int DEF_TIME_W = 11;
    localparam int DEF_AMT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CALC        = 3'd1,
        ST_WAIT_PAY    = 3'd2,
        ST_CHANGE      = 3'd3,
        ST_DONE        = 3'd4,
        ST_REFUND      = 3'd5,
        ST_REFUND_DONE = 3'd6
    } park_state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_1    = 2'd1;
    localparam logic [1:0] COIN_5    = 2'd2;
    localparam logic [1:0] COIN_10   = 2'd3;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] value;
        case (code)
            COIN_1:  value = 4'd1;
            COIN_5:  value = 4'd5;
            COIN_10: value = 4'd10;
            default: value = 4'd0;
        endcase
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coin_dispenser.sv
// ============================================================================
// Module   : coin_dispenser
// Purpose  : Greedy one-coin-at-a-time payout of a loaded amount (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_dispenser
    import parking_pkg::*;
#(
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             firstInteract,
    input  logic             i_load,
    input  logic [AMT_W-1:0] i_load_amount,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [1:0]       o_out_code,
    output logic             o_last,
    output logic             o_empty
);

    logic [AMT_W-1:0] r_remaining;
    logic [1:0]       w_code;
    logic [3:0]       w_value;

    // Coin choice depends only on the registered remainder, so the code
    // stays put for as long as the dispenser withholds out_ready.
    always_comb begin
        w_code = COIN_NONE;
        if (r_remaining >= AMT_W'(10)) begin
            w_code = COIN_10;
        end else if (r_remaining >= AMT_W'(5)) begin
            w_code = COIN_5;
        end else if (r_remaining != '0) begin
            w_code = COIN_1;
        end
    end

    assign w_value     = coin_value(w_code);
    assign o_out_valid = (r_remaining != '0);
    assign o_out_code  = w_code;
    assign o_empty     = (r_remaining == '0);
    assign o_last      = o_out_valid && i_out_ready && (r_remaining == AMT_W'(w_value));

    always_ff @(posedge clk or posedge firstInteract) begin
        if (firstInteract) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_amount;
        end else if (o_out_valid && i_out_ready) begin
            r_remaining <= r_remaining - AMT_W'(w_value);
        end
    end

endmodule

`default_nettype wire

// File: rtl/parking_fee_payment.sv
// ============================================================================
// Module   : parking_fee_payment
// Purpose  : Bills elapsed parking time, collects coins, pays change/refunds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_fee_payment
    import parking_pkg::*;
#(
    parameter int          TIME_W  = DEF_TIME_W,
    parameter int          AMT_W   = DEF_AMT_W,
    parameter int unsigned RATE    = 2,
    parameter int unsigned GRACE   = 5,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              firstInteract,
    input  logic              start,
    input  logic [TIME_W-1:0] fee,
    input  logic              coin_valid,
    input  logic [1:0]        coin_code,
    input  logic              cancel,
    output logic              coin_accept,
    output logic [AMT_W-1:0]  amount_due,
    output logic [AMT_W-1:0]  amount_paid,
    output logic              out_valid,
    output logic [1:0]        out_code,
    input  logic              out_ready,
    output logic              paid_done,
    output logic              refunded,
    output logic              busy
);

    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int PROD_W = TIME_W + 32;

    park_state_t       r_state;
    logic [TIME_W-1:0] r_fee;
    logic [TMR_W-1:0]  r_timer;
    logic [AMT_W-1:0]  r_amount_due;
    logic [AMT_W-1:0]  r_amount_paid;
    logic              r_coin_accept;
    logic              r_paid_done;
    logic              r_refunded;
    logic              r_busy;

    logic [TIME_W-1:0] w_billable;
    logic [PROD_W-1:0] w_due_full;
    logic [AMT_W-1:0]  w_due_calc;
    logic [3:0]        w_coin_value;
    logic              w_coin_in;
    logic [AMT_W-1:0]  w_paid_next;
    logic              w_covered;
    logic              w_timeout;
    logic              w_go_refund;
    logic              w_go_change;
    logic              w_disp_load;
    logic [AMT_W-1:0]  w_disp_amount;
    logic              w_disp_last;
    logic              w_disp_empty;

    // Billing: subtract grace period, scale by rate, clamp to the money width.
    assign w_billable = (r_fee > TIME_W'(GRACE)) ? (r_fee - TIME_W'(GRACE)) : '0;
    assign w_due_full = PROD_W'(w_billable) * PROD_W'(RATE);
    assign w_due_calc = ((w_due_full >> AMT_W) != '0) ? {AMT_W{1'b1}}
                                                      : w_due_full[AMT_W-1:0];

    // Transition decisions see the total including this cycle's coin.
    assign w_coin_value = coin_valid ? coin_value(coin_code) : 4'd0;
    assign w_coin_in    = (w_coin_value != 4'd0);
    assign w_paid_next  = r_amount_paid + AMT_W'(w_coin_value);
    assign w_covered    = (w_paid_next >= r_amount_due);
    assign w_timeout    = !w_coin_in && (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_go_refund  = cancel || (!w_covered && w_timeout);
    assign w_go_change  = !cancel && w_covered && (w_paid_next != r_amount_due);

    assign w_disp_load   = (r_state == ST_WAIT_PAY) && (w_go_refund || w_go_change);
    assign w_disp_amount = w_go_refund ? w_paid_next : (w_paid_next - r_amount_due);

    coin_dispenser #(
        .AMT_W (AMT_W)
    ) u_coin_dispenser (
        .clk           (clk),
        .firstInteract (firstInteract),
        .i_load        (w_disp_load),
        .i_load_amount (w_disp_amount),
        .i_out_ready   (out_ready),
        .o_out_valid   (out_valid),
        .o_out_code    (out_code),
        .o_last        (w_disp_last),
        .o_empty       (w_disp_empty)
    );

    always_ff @(posedge clk or posedge firstInteract) begin
        if (firstInteract) begin
            r_state       <= ST_IDLE;
            r_fee         <= '0;
            r_timer       <= '0;
            r_amount_due  <= '0;
            r_amount_paid <= '0;
            r_coin_accept <= 1'b0;
            r_paid_done   <= 1'b0;
            r_refunded    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fee   <= fee;
                        r_state <= ST_CALC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_amount_due <= w_due_calc;
                    r_timer      <= '0;
                    if (w_due_calc == '0) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_paid_done <= 1'b1;
                    end else begin
                        r_state       <= ST_WAIT_PAY;
                        r_coin_accept <= 1'b1;
                    end
                end
                ST_WAIT_PAY: begin
                    r_amount_paid <= w_paid_next;
                    r_timer       <= w_coin_in ? '0 : (r_timer + 1'b1);
                    if (w_go_refund) begin
                        r_state       <= ST_REFUND;
                        r_coin_accept <= 1'b0;
                    end else if (w_covered) begin
                        r_coin_accept <= 1'b0;
                        if (w_go_change) begin
                            r_state <= ST_CHANGE;
                        end else begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_paid_done <= 1'b1;
                        end
                    end
                end
                ST_CHANGE: begin
                    if (w_disp_empty || w_disp_last) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_paid_done <= 1'b1;
                    end
                end
                ST_REFUND: begin
                    // A cancel before any coin leaves nothing to pay out.
                    if (w_disp_empty || w_disp_last) begin
                        r_state    <= ST_REFUND_DONE;
                        r_busy     <= 1'b0;
                        r_refunded <= 1'b1;
                    end
                end
                ST_DONE, ST_REFUND_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign coin_accept = r_coin_accept;
    assign amount_due  = r_amount_due;
    assign amount_paid = r_amount_paid;
    assign paid_done   = r_paid_done;
    assign refunded    = r_refunded;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_parking_fee_payment.sv
// ============================================================================
// Module   : tb_parking_fee_payment
// Purpose  : Self-checking bench for parking_fee_payment with a payment model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_fee_payment;

    localparam int TIME_W  = 11;
    localparam int AMT_W   = 16;
    localparam int RATE    = 2;
    localparam int GRACE   = 5;
    localparam int TIMEOUT = 8;

    localparam int M_IDLE  = 0;
    localparam int M_CALC  = 1;
    localparam int M_PAY   = 2;
    localparam int M_CHG   = 3;
    localparam int M_DONE  = 4;
    localparam int M_REF   = 5;
    localparam int M_RDONE = 6;

    logic              clk = 1'b0;
    logic              firstInteract = 1'b1;
    logic              start = 1'b0;
    logic [TIME_W-1:0] fee = '0;
    logic              coin_valid = 1'b0;
    logic [1:0]        coin_code = 2'd0;
    logic              cancel = 1'b0;
    logic              out_ready = 1'b0;
    logic              coin_accept;
    logic [AMT_W-1:0]  amount_due;
    logic [AMT_W-1:0]  amount_paid;
    logic              out_valid;
    logic [1:0]        out_code;
    logic              paid_done;
    logic              refunded;
    logic              busy;

    int checks = 0;
    int failures = 0;

    int m_phase = M_IDLE;
    int m_fee = 0;
    int m_due = 0;
    int m_paid = 0;
    int m_rem = 0;
    int m_timer = 0;

    parking_fee_payment #(
        .TIME_W  (TIME_W),
        .AMT_W   (AMT_W),
        .RATE    (RATE),
        .GRACE   (GRACE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .firstInteract (firstInteract),
        .start         (start),
        .fee           (fee),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .cancel        (cancel),
        .coin_accept   (coin_accept),
        .amount_due    (amount_due),
        .amount_paid   (amount_paid),
        .out_valid     (out_valid),
        .out_code      (out_code),
        .out_ready     (out_ready),
        .paid_done     (paid_done),
        .refunded      (refunded),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic int coin_val(input int code);
        case (code)
            1: return 1;
            2: return 5;
            3: return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int biggest(input int rem);
        if (rem >= 10) return 3;
        if (rem >= 5) return 2;
        if (rem > 0) return 1;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of the kiosk payment flow.
    always @(posedge clk or posedge firstInteract) begin
        if (firstInteract) begin
            m_phase = M_IDLE;
            m_fee = 0; m_due = 0; m_paid = 0; m_rem = 0; m_timer = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin m_fee = int'(fee); m_phase = M_CALC; end
                M_CALC: begin
                    m_due = (m_fee > GRACE) ? (m_fee - GRACE) * RATE : 0;
                    if (m_due > 65535) m_due = 65535;
                    m_timer = 0;
                    m_phase = (m_due == 0) ? M_DONE : M_PAY;
                end
                M_PAY: begin
                    int v;
                    int old_timer;
                    v = coin_valid ? coin_val(int'(coin_code)) : 0;
                    old_timer = m_timer;
                    m_paid = m_paid + v;
                    m_timer = (v != 0) ? 0 : m_timer + 1;
                    if (cancel) begin
                        m_rem = m_paid; m_phase = M_REF;
                    end else if (m_paid >= m_due) begin
                        m_rem = m_paid - m_due;
                        m_phase = (m_rem > 0) ? M_CHG : M_DONE;
                    end else if (v == 0 && old_timer == TIMEOUT - 1) begin
                        m_rem = m_paid; m_phase = M_REF;
                    end
                end
                M_CHG, M_REF: begin
                    if (m_rem > 0 && out_ready) m_rem = m_rem - coin_val(biggest(m_rem));
                    if (m_rem == 0) m_phase = (m_phase == M_CHG) ? M_DONE : M_RDONE;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        int exp_ov;
        exp_ov = ((m_phase == M_CHG || m_phase == M_REF) && m_rem > 0) ? 1 : 0;
        check("coin_accept", int'(coin_accept), (m_phase == M_PAY) ? 1 : 0);
        check("amount_due", int'(amount_due), m_due);
        check("amount_paid", int'(amount_paid), m_paid);
        check("out_valid", int'(out_valid), exp_ov);
        check("out_code", int'(out_code), exp_ov ? biggest(m_rem) : 0);
        check("paid_done", int'(paid_done), (m_phase == M_DONE) ? 1 : 0);
        check("refunded", int'(refunded), (m_phase == M_RDONE) ? 1 : 0);
        check("busy", int'(busy),
              (m_phase == M_CALC || m_phase == M_PAY || m_phase == M_CHG || m_phase == M_REF) ? 1 : 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        firstInteract = 1'b1;
        start = 1'b0; coin_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0;
        step();
        step();
        firstInteract = 1'b0;
    endtask

    task automatic begin_bill(input int f);
        fee = TIME_W'(f);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic insert(input int code, input bit with_cancel);
        coin_valid = 1'b1;
        coin_code = 2'(code);
        cancel = with_cancel;
        step();
        coin_valid = 1'b0;
        cancel = 1'b0;
    endtask

    initial begin
        // Exact payment: 30 due, three 10-coins.
        do_reset();
        begin_bill(20);
        step();
        check("lit_due_30", int'(amount_due), 30);
        check("lit_accept_open", int'(coin_accept), 1);
        insert(3, 0); insert(3, 0); insert(3, 0);
        check("lit_exact_done", int'(paid_done), 1);
        check("lit_exact_no_out", int'(out_valid), 0);
        check("lit_exact_paid", int'(amount_paid), 30);

        // Overpayment of 5 yields one 5-coin of change.
        do_reset();
        begin_bill(20);
        step();
        insert(3, 0); insert(3, 0); insert(2, 0); insert(3, 0);
        check("lit_change_valid", int'(out_valid), 1);
        check("lit_change_code", int'(out_code), 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("lit_change_done", int'(paid_done), 1);
        check("lit_change_drop", int'(out_valid), 0);

        // Fee within grace: nothing due.
        do_reset();
        begin_bill(3);
        check("lit_grace_busy", int'(busy), 1);
        check("lit_grace_not_yet", int'(paid_done), 0);
        step();
        check("lit_grace_done", int'(paid_done), 1);
        check("lit_grace_no_accept", int'(coin_accept), 0);

        // Cancel with a same-cycle 1-coin refunds 16 as 10, 5, 1.
        do_reset();
        begin_bill(20);
        step();
        insert(3, 0); insert(2, 0); insert(1, 1);
        check("lit_refund_paid", int'(amount_paid), 16);
        check("lit_refund_code10", int'(out_code), 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lit_refund_hold", int'(out_code), 3);
        end
        out_ready = 1'b1;
        step();
        check("lit_refund_code5", int'(out_code), 2);
        step();
        check("lit_refund_code1", int'(out_code), 1);
        step();
        out_ready = 1'b0;
        check("lit_refunded", int'(refunded), 1);

        // Inactivity timeout after a single 5-coin.
        do_reset();
        begin_bill(20);
        step();
        insert(2, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("lit_timeout_still_open", int'(coin_accept), 1);
        step();
        check("lit_timeout_refund_code", int'(out_code), 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("lit_timeout_refunded", int'(refunded), 1);

        // Asynchronous reset in the middle of change dispensing.
        do_reset();
        begin_bill(20);
        step();
        insert(3, 0); insert(3, 0); insert(2, 0); insert(3, 0);
        check("lit_pre_reset_valid", int'(out_valid), 1);
        #2 firstInteract = 1'b1;
        #1;
        check("lit_async_out_valid", int'(out_valid), 0);
        check("lit_async_due", int'(amount_due), 0);
        check("lit_async_paid", int'(amount_paid), 0);
        check("lit_async_busy", int'(busy), 0);
        step();
        firstInteract = 1'b0;
        begin_bill(10);
        step();
        check("lit_restart_due", int'(amount_due), 10);

        // Randomised sessions against the model.
        for (int t = 0; t < 40; t++) begin
            int coin_rate;
            int cyc;
            do_reset();
            coin_rate = ($urandom_range(0, 1) == 0) ? 1 : 12;
            begin_bill(int'($urandom_range(0, 40)));
            cyc = 0;
            while (m_phase != M_DONE && m_phase != M_RDONE && cyc < 300) begin
                coin_valid = ($urandom_range(0, coin_rate) == 0);
                coin_code  = 2'($urandom_range(0, 3));
                cancel     = ($urandom_range(0, 40) == 0);
                out_ready  = ($urandom_range(0, 1) == 1);
                start      = ($urandom_range(0, 15) == 0);
                fee        = TIME_W'($urandom_range(0, 2047));
                step();
                cyc++;
            end
            start = 1'b0; coin_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0;
            check("rand_session_ends", (cyc < 300) ? 1 : 0, 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/parking_fee_payment.md
Name: parking_fee_payment

Overview:
- Downstream of the check-in/check-out stage. It consumes the 11-bit elapsed-time `fee` produced at check-out and converts it into an amount owed.
- It collects coins until the amount owed is covered, then dispenses change one coin at a time and signals completion.
- On cancel or inactivity timeout, it refunds everything paid so far.
- Each new user interaction on the kiosk clears the block through its reset.

Parameters:
- TIME_W, 11: width of the incoming `fee` (elapsed time units).
- AMT_W, 16: width of all money quantities.
- RATE, 2: money units charged per billable time unit.
- GRACE, 5: free time units subtracted before billing.
- TIMEOUT, 1000: clk cycles without a coin in WAIT_PAY before auto-refund.

Ports:
- clk  in  1  system clock
- firstInteract  in  1  reset firstInteract, asynchronous, active-high
- start  in  1  one-cycle strobe: `fee` valid, begin billing (top issues it after firstInteract falls)
- fee  in  TIME_W  elapsed parking time from check-out
- coin_valid  in  1  coin inserted this cycle
- coin_code  in  2  inserted coin: 0=ignore, 1=1, 2=5, 3=10 units
- cancel  in  1  user abort
- coin_accept  out  1  coin slot open (high only in WAIT_PAY)
- amount_due  out  AMT_W  billed amount
- amount_paid  out  AMT_W  running total inserted
- out_valid  out  1  dispensing a coin (change or refund)
- out_code  out  2  coin being dispensed, same encoding as coin_code
- out_ready  in  1  dispenser took coin this cycle
- paid_done  out  1  level: payment complete, change fully dispensed
- refunded  out  1  level: refund complete
- busy  out  1  high in every state except IDLE/DONE/REFUND_DONE

Behaviour:
- Reset (firstInteract high, async):
  - State goes to IDLE.
  - All outputs are 0.
  - All registers (remaining, timer) are 0.
- States: IDLE, CALC, WAIT_PAY, CHANGE, DONE, REFUND, REFUND_DONE.
- IDLE: on `start`, capture `fee` and go to CALC. `start` is ignored in all other states.
- CALC (exactly 1 cycle):
  - billable = (fee > GRACE) ? fee-GRACE : 0.
  - amount_due = billable*RATE, saturated to 2^AMT_W-1.
  - If amount_due==0, go to DONE. Otherwise go to WAIT_PAY.
- WAIT_PAY:
  - coin_accept=1.
  - On coin_valid with code≠0: amount_paid += value, timer cleared.
  - Otherwise timer increments each cycle.
  - Transition evaluation uses the updated amount_paid, next cycle:
    - If cancel is high: go to REFUND with remaining=amount_paid. A coin in the same cycle is counted first, so it is refunded. Cancel has priority over reaching due.
    - Else if amount_paid ≥ amount_due: remaining=paid-due. Go to CHANGE if remaining>0, else DONE.
    - Else if timer==TIMEOUT-1: go to REFUND.
  - A code-0 coin is ignored and does not clear the timer.
- CHANGE / REFUND (greedy dispense):
  - out_valid=1; out_code = largest coin ≤ remaining (10, 5, then 1).
  - On out_ready: remaining -= value.
  - When remaining becomes 0, go to DONE (CHANGE) or REFUND_DONE (REFUND). out_valid drops the same cycle the state changes.
  - out_code is held stable while out_valid && !out_ready.
  - coin_valid and cancel are ignored.
- DONE: paid_done=1, held until reset. REFUND_DONE: refunded=1, held until reset.
- Reset mid-operation aborts immediately. No coins are dispensed after reset; undispensed money is lost by design.
- amount_paid does not need a saturation guard: it stops accepting once it reaches ≥ due, and the maximum overshoot is 9.

Decomposition:
- Shared package `parking_pkg`:
  - State enum.
  - Coin code constants COIN_NONE/1/5/10.
  - Coin value lookup function.
  - TIME_W/AMT_W defaults (also used by the check-in/check-out stage).
- One natural sub-module: `coin_dispenser`.
  - Holds remaining, greedy coin select, and the valid/ready handshake.
  - Reused for both change and refund; its load/done interface is driven by the parent FSM.

Test Plan:
- RATE=2, GRACE=5, fee=20, start → amount_due=30. Then coins 10,10,10 → paid_done=1, out_valid never asserted.
- fee=20, coins 10,10,5,10 (paid 35) → CHANGE emits a single out_code=2 (5). paid_done rises after out_ready.
- fee=3 → amount_due=0 → DONE two cycles after start, coin_accept never high.
- fee=20, coins 10,5, then cancel asserted in the same cycle as a coin 1 → refund remaining=16, dispensed as 10, 5, 1. out_ready held low for 3 cycles keeps out_code=3 stable. Ends with refunded=1.
- TIMEOUT=8, fee=20, coin 5, then idle 8 cycles → REFUND of one 5-coin → refunded=1.
- Assert firstInteract while in CHANGE with out_valid high → all outputs 0 asynchronously. A new start with fee=10 → amount_due=10.
